// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and default latencies.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int DEFAULT_MULT_CYCLES = 5;
  localparam int DEFAULT_DIV_CYCLES  = 10;

  function automatic int max_int(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/mdu.sv
// MIPS multiply/divide unit with architectural HI/LO, a fixed-latency busy
// window and single-cycle MTHI/MTLO.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_W = $clog2(max_int(MULT_CYCLES, DIV_CYCLES) + 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic             pend_wr_q, pend_wr_d;

  mdu_op_e          op_e;
  logic [63:0]      prod_s, prod_u;
  logic [31:0]      b_safe;
  logic             div_ovf;
  logic signed [31:0] quot_s, rem_s;
  logic [31:0]      quot_u, rem_u;

  assign op_e = mdu_op_e'(op);

  // Zero and the INT_MIN/-1 overflow case are steered to a divisor of 1 so
  // the behavioural divider never sees an undefined division.
  always_comb begin
    prod_s  = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u  = {32'd0, a} * {32'd0, b};
    div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    b_safe  = ((b == 32'd0) || div_ovf) ? 32'd1 : b;
    quot_s  = $signed(a) / $signed(b_safe);
    rem_s   = $signed(a) % $signed(b_safe);
    quot_u  = a / b_safe;
    rem_u   = a % b_safe;
    if (div_ovf) begin
      quot_s = $signed(32'h8000_0000);
      rem_s  = '0;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op_e)
            OP_MULT: begin
              state_d   = ST_RUN;
              cnt_d     = CNT_W'(MULT_CYCLES);
              pend_hi_d = prod_s[63:32];
              pend_lo_d = prod_s[31:0];
              pend_wr_d = 1'b1;
            end
            OP_MULTU: begin
              state_d   = ST_RUN;
              cnt_d     = CNT_W'(MULT_CYCLES);
              pend_hi_d = prod_u[63:32];
              pend_lo_d = prod_u[31:0];
              pend_wr_d = 1'b1;
            end
            OP_DIV: begin
              state_d   = ST_RUN;
              cnt_d     = CNT_W'(DIV_CYCLES);
              pend_hi_d = rem_s;
              pend_lo_d = quot_s;
              pend_wr_d = (b != 32'd0);
            end
            OP_DIVU: begin
              state_d   = ST_RUN;
              cnt_d     = CNT_W'(DIV_CYCLES);
              pend_hi_d = rem_u;
              pend_lo_d = quot_u;
              pend_wr_d = (b != 32'd0);
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Commit edge: divide-by-zero leaves HI/LO untouched.
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: a cycle-level arithmetic model compared every
// cycle, plus literal expectations for the directed vectors.
module tb_mdu;
  import mdu_pkg::*;

  localparam int MULT_L = 5;
  localparam int DIV_L  = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int compared   = 0;
  int mismatched = 0;
  bit check_en   = 0;

  mdu #(.MULT_CYCLES(MULT_L), .DIV_CYCLES(DIV_L)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: tracks the edge count and commits the arithmetic
  // result when the edge number reaches start edge + latency.
  bit          m_busy = 0;
  bit          m_wr   = 0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;
  logic [31:0] p_hi   = '0;
  logic [31:0] p_lo   = '0;
  longint      edge_n = 0;
  longint      commit_edge = 0;

  always @(posedge clk or negedge reset) begin
    longint sa, sb, res, q, r;
    longint unsigned ua, ub, ures;
    if (!reset) begin
      m_busy = 0; m_wr = 0; m_hi = '0; m_lo = '0; edge_n = 0;
    end else begin
      edge_n++;
      if (m_busy) begin
        if (edge_n == commit_edge) begin
          if (m_wr) begin m_hi = p_hi; m_lo = p_lo; end
          m_busy = 0;
        end
      end else if (start) begin
        sa = $signed(a); sb = $signed(b);
        ua = {32'd0, a}; ub = {32'd0, b};
        case (op)
          OP_MULT: begin
            res = sa * sb; p_hi = res[63:32]; p_lo = res[31:0];
            m_wr = 1; m_busy = 1; commit_edge = edge_n + MULT_L;
          end
          OP_MULTU: begin
            ures = ua * ub; p_hi = ures[63:32]; p_lo = ures[31:0];
            m_wr = 1; m_busy = 1; commit_edge = edge_n + MULT_L;
          end
          OP_DIV: begin
            m_wr = (b != 0); m_busy = 1; commit_edge = edge_n + DIV_L;
            if (b != 0) begin
              q = sa / sb; r = sa % sb; p_lo = q[31:0]; p_hi = r[31:0];
            end
          end
          OP_DIVU: begin
            m_wr = (b != 0); m_busy = 1; commit_edge = edge_n + DIV_L;
            if (b != 0) begin
              ures = ua / ub; p_lo = ures[31:0];
              ures = ua % ub; p_hi = ures[31:0];
            end
          end
          OP_MTHI: m_hi = a;
          OP_MTLO: m_lo = a;
          default: ;
        endcase
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("model_busy", {31'd0, busy}, {31'd0, m_busy});
      checkOutput("model_hi", hi, m_hi);
      checkOutput("model_lo", lo, m_lo);
    end
  end

  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] x,
                               input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic waitIdle(output int cycles);
    cycles = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      cycles++;
    end
  endtask

  task automatic runOp(input string name, input logic [2:0] o,
                       input logic [31:0] x, input logic [31:0] y,
                       input int exp_cycles, input logic [31:0] exp_hi,
                       input logic [31:0] exp_lo);
    int cyc;
    applyStimulus(o, x, y);
    waitIdle(cyc);
    checkOutput({name, "_cycles"}, 32'(cyc), 32'(exp_cycles));
    checkOutput({name, "_hi"}, hi, exp_hi);
    checkOutput({name, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    #3 reset = 1'b0;
    repeat (2) @(negedge clk);
    check_en = 1;
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_hi", hi, 32'd0);
    checkOutput("reset_lo", lo, 32'd0);
    @(negedge clk) reset = 1'b1;

    runOp("mult",  OP_MULT,  32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    runOp("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
    runOp("div",   OP_DIV,   32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    runOp("divu",  OP_DIVU,  32'd7, 32'd2, 10, 32'd1, 32'd3);
    runOp("mthi",  OP_MTHI,  32'h11, 32'd0, 0, 32'h11, 32'd3);
    runOp("mtlo",  OP_MTLO,  32'h22, 32'd0, 0, 32'h11, 32'h22);
    runOp("divz",  OP_DIVU,  32'd7, 32'd0, 10, 32'h11, 32'h22);

    // Starts issued while busy must be dropped.
    applyStimulus(OP_DIV, 32'd100, 32'd7);
    applyStimulus(OP_MTHI, 32'hDEAD, 32'd0);
    applyStimulus(OP_MULT, 32'd3, 32'd3);
    waitIdle(cyc);
    checkOutput("ignore_cycles", 32'(cyc), 32'd8);
    checkOutput("ignore_hi", hi, 32'd2);
    checkOutput("ignore_lo", lo, 32'd14);

    runOp("divovf", OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
    runOp("b2b",    OP_MULTU, 32'd3, 32'd4, 5, 32'd0, 32'd12);
    runOp("rsvd",   3'd6,     32'h55, 32'h66, 0, 32'd0, 32'd12);

    // Asynchronous reset two cycles into a MULT busy window.
    applyStimulus(OP_MULT, 32'd3, 32'd5);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_hi", hi, 32'd0);
    checkOutput("midrst_lo", lo, 32'd0);
    @(negedge clk) reset = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("nocommit_busy", {31'd0, busy}, 32'd0);
    checkOutput("nocommit_hi", hi, 32'd0);
    checkOutput("nocommit_lo", lo, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit with architectural HI/LO registers for the MIPS datapath. Sits directly downstream of the register file: consumes the two GRF read-data operands and executes MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency, plus the single-cycle MTHI/MTLO. A `busy` flag is exported so the controller can stall. HI/LO are read combinationally by the MFHI/MFLO path.

## Interface
- `MULT_CYCLES`, 5, busy cycles for MULT/MULTU (≥1).
- `DIV_CYCLES`, 10, busy cycles for DIV/DIVU (≥1).
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request strobe; sampled at the rising edge.
- `op`  in  3  operation: MULT, MULTU, DIV, DIVU, MTHI, MTLO; other codes reserved.
- `a`  in  32  operand rs (GRF ReadData1).
- `b`  in  32  operand rt (GRF ReadData2).
- `busy`  out  1  high while a mult/div is in flight.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- Reset low, at any time, including mid-operation: `busy`=0, `hi`=0, `lo`=0, cycle counter=0, pending result discarded. Reset is not synchronised internally; deassertion is clean relative to `clk`.
- Idle (`busy`=0) with `start`=1 samples `op`:
  - MULT: signed 32×32→64 product; HI=bits[63:32], LO=bits[31:0].
  - MULTU: same, unsigned.
  - DIV: signed; LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - DIVU: unsigned quotient/remainder.
  - MTHI: HI←`a` at that edge; LO unchanged; `busy` stays 0.
  - MTLO: LO←`a` at that edge; HI unchanged; `busy` stays 0.
  - Reserved op: ignored; no state change.
- Mult/div result is computed from operands captured at the start edge and held in a pending register. HI/LO keep their old values until the commit edge.
- Divide by zero (`b`=0, DIV or DIVU): full DIV_CYCLES busy period; HI/LO unchanged at commit.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- `start` while `busy`=1: ignored for all ops, including MTHI/MTLO. The controller stalls instead.
- States: IDLE (counter=0) and RUN (counter>0). IDLE goes to RUN on a mult/div start, loading the counter with the latency. RUN decrements the counter each edge. On the edge where the counter goes 1→0, HI/LO are written from pending and the unit returns to IDLE.

## Timing
- Start sampled at edge E0. `busy`=1 from after E0 through the cycle ending at edge E0+L, where L=MULT_CYCLES or DIV_CYCLES. `busy` is asserted for exactly L cycles.
- HI/LO new values are visible after edge E0+L, in the same cycle that `busy` falls.
- A new start is accepted at edge E0+L+1 at the earliest. There is no back-to-back overlap with the commit edge.
- MTHI/MTLO: latency 1 edge; value visible after E0.
- `busy`, `hi`, `lo` are registered outputs; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `mdu_pkg`:
  - op encodings MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5;
  - default latency constants.
- Arithmetic uses behavioural `*`, `/`, `%` on explicitly signed/unsigned 32-bit copies, computing the result in the start cycle. No sub-module is warranted; counter, pending register, and HI/LO live in one module.

## Test plan
- Reset low mid-MULT (2 cycles into busy) → `busy`=0, `hi`=`lo`=0 immediately; no later commit.
- MULT a=0xFFFFFFFF b=2 → `busy` high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (−7) b=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=7 b=2 → LO=3, HI=1.
- HI=0x11, LO=0x22 preloaded via MTHI/MTLO (each `busy`=0, visible next cycle); then DIVU a=7 b=0 → 10 busy cycles, HI=0x11, LO=0x22 unchanged.
- During a DIV busy period, pulse `start` with MTHI a=0xDEAD and with MULT → both ignored; final HI/LO equal the DIV result only.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0; then an immediate start at E0+11 is accepted.
